// File: rtl/cv32e40p_seq_comparator.sv
// Multi-cycle wide-operand comparator: scans operands MSB-first in CHUNK-bit slices,
// stopping at the first differing slice; covers the compare and min/max ALU opcodes.

package cv32e40p_pkg;
  typedef enum logic [6:0] {
    ALU_LTS   = 7'b0000000,
    ALU_LTU   = 7'b0000001,
    ALU_SLTS  = 7'b0000010,
    ALU_SLTU  = 7'b0000011,
    ALU_LES   = 7'b0000100,
    ALU_LEU   = 7'b0000101,
    ALU_SLETS = 7'b0000110,
    ALU_SLETU = 7'b0000111,
    ALU_GTS   = 7'b0001000,
    ALU_GTU   = 7'b0001001,
    ALU_GES   = 7'b0001010,
    ALU_GEU   = 7'b0001011,
    ALU_EQ    = 7'b0001100,
    ALU_NE    = 7'b0001101,
    ALU_MIN   = 7'b0010000,
    ALU_MAX   = 7'b0010001,
    ALU_MINU  = 7'b0010010,
    ALU_MAXU  = 7'b0010011,
    ALU_ADD   = 7'b0011000,
    ALU_SUB   = 7'b0011001,
    ALU_XOR   = 7'b0101111
  } alu_opcode_e;
endpackage

// state | meaning
// IDLE  | waiting for a request, ready_o high
// SCAN  | comparing one slice per cycle, top slice first
// DONE  | result held on the outputs until ready_i
module cv32e40p_seq_comparator
  import cv32e40p_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  alu_opcode_e      operator_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             comparison_result_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [WIDTH-1:0]  a_q, b_q, a_cmp, b_cmp;
  alu_opcode_e       op_q;
  logic              signed_q, lt_q, eq_q, hit_q;
  logic [CHUNK-1:0]  slice_a, slice_b;
  logic              slice_lt, slice_eq, last_slice;
  logic [WIDTH-1:0]  result_q, res_d;
  logic              cmp_q, cmp_d;

  function automatic logic is_signed(input alu_opcode_e op);
    return op inside {ALU_LTS, ALU_GES, ALU_GTS, ALU_LES, ALU_SLTS, ALU_SLETS, ALU_MIN, ALU_MAX};
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_cmp = {a_q[WIDTH-1] ^ signed_q, a_q[WIDTH-2:0]};
  assign b_cmp = {b_q[WIDTH-1] ^ signed_q, b_q[WIDTH-2:0]};

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_a = a_cmp[i*CHUNK +: CHUNK];
        slice_b = b_cmp[i*CHUNK +: CHUNK];
      end
    end
  end

  assign slice_lt   = slice_a < slice_b;
  assign slice_eq   = slice_a == slice_b;
  assign last_slice = idx_q == '0;

  always_comb begin
    res_d = '0;
    cmp_d = 1'b0;
    unique case (op_q)
      ALU_LTS, ALU_LTU, ALU_SLTS, ALU_SLTU: begin
        cmp_d = lt_q;
        res_d = {{(WIDTH-1){1'b0}}, cmp_d};
      end
      ALU_LES, ALU_LEU, ALU_SLETS, ALU_SLETU: begin
        cmp_d = lt_q | eq_q;
        res_d = {{(WIDTH-1){1'b0}}, cmp_d};
      end
      ALU_GTS, ALU_GTU: begin
        cmp_d = ~lt_q & ~eq_q;
        res_d = {{(WIDTH-1){1'b0}}, cmp_d};
      end
      ALU_GES, ALU_GEU: begin
        cmp_d = ~lt_q;
        res_d = {{(WIDTH-1){1'b0}}, cmp_d};
      end
      ALU_EQ: begin
        cmp_d = eq_q;
        res_d = {{(WIDTH-1){1'b0}}, cmp_d};
      end
      ALU_NE: begin
        cmp_d = ~eq_q;
        res_d = {{(WIDTH-1){1'b0}}, cmp_d};
      end
      ALU_MIN, ALU_MINU: begin
        cmp_d = lt_q;
        res_d = (lt_q | eq_q) ? a_q : b_q;
      end
      ALU_MAX, ALU_MAXU: begin
        cmp_d = lt_q;
        res_d = lt_q ? b_q : a_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_i) state_d = SCAN;
      SCAN:    if (hit_q) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // hit_q marks the deciding slice; the result is formed from lt_q/eq_q the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      signed_q <= 1'b0;
      idx_q    <= '0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      hit_q    <= 1'b0;
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && valid_i && !flush_i) begin
        a_q      <= operand_a_i;
        b_q      <= operand_b_i;
        op_q     <= operator_i;
        signed_q <= is_signed(operator_i);
        idx_q    <= IDX_W'(NCHUNK - 1);
        lt_q     <= 1'b0;
        eq_q     <= 1'b0;
        hit_q    <= 1'b0;
      end
      if (state_q == SCAN && !hit_q) begin
        lt_q  <= slice_lt;
        eq_q  <= slice_eq;
        hit_q <= ~slice_eq | last_slice;
        if (slice_eq && !last_slice) idx_q <= idx_q - 1'b1;
      end
      if (state_q == SCAN && hit_q && !flush_i) begin
        result_q <= res_d;
        cmp_q    <= cmp_d;
      end
    end
  end

  assign ready_o             = (state_q == IDLE) & ~rst;
  assign valid_o             = state_q == DONE;
  assign result_o            = result_q;
  assign comparison_result_o = cmp_q;

endmodule

// File: tb/tb_cv32e40p_seq_comparator.sv
// Directed bench for cv32e40p_seq_comparator (WIDTH=64, CHUNK=16) with an arithmetic
// reference model and a per-cycle output monitor.

module tb_cv32e40p_seq_comparator;
  import cv32e40p_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  alu_opcode_e operator_i = ALU_ADD;
  logic [63:0] operand_a_i = '0;
  logic [63:0] operand_b_i = '0;
  logic        ready_o, valid_o, comparison_result_o;
  logic [63:0] result_o;

  cv32e40p_seq_comparator #(.WIDTH(64), .CHUNK(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush_i),
    .valid_i             (valid_i),
    .ready_o             (ready_o),
    .operator_i          (operator_i),
    .operand_a_i         (operand_a_i),
    .operand_b_i         (operand_b_i),
    .valid_o             (valid_o),
    .ready_i             (ready_i),
    .result_o            (result_o),
    .comparison_result_o (comparison_result_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic        expect_valid = 1'b0;
  logic [63:0] exp_res = '0;
  logic        exp_cmp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input alu_opcode_e op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output logic cmp);
    logic lt, eq, sgn;
    sgn = op inside {ALU_LTS, ALU_GES, ALU_GTS, ALU_LES, ALU_SLTS, ALU_SLETS, ALU_MIN, ALU_MAX};
    lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
    eq  = (a == b);
    res = '0;
    cmp = 1'b0;
    case (op)
      ALU_LTS, ALU_LTU, ALU_SLTS, ALU_SLTU:   begin cmp = lt;         res = {63'd0, cmp}; end
      ALU_LES, ALU_LEU, ALU_SLETS, ALU_SLETU: begin cmp = lt || eq;   res = {63'd0, cmp}; end
      ALU_GTS, ALU_GTU:                       begin cmp = !lt && !eq; res = {63'd0, cmp}; end
      ALU_GES, ALU_GEU:                       begin cmp = !lt;        res = {63'd0, cmp}; end
      ALU_EQ:                                 begin cmp = eq;         res = {63'd0, cmp}; end
      ALU_NE:                                 begin cmp = !eq;        res = {63'd0, cmp}; end
      ALU_MIN, ALU_MINU:                      begin cmp = lt; res = (lt || eq) ? a : b; end
      ALU_MAX, ALU_MAXU:                      begin cmp = lt; res = !lt ? a : b; end
      default: ;
    endcase
  endfunction

  // Cycles from accept to valid_o: one more than the number of slices looked at.
  function automatic int model_latency(input logic [63:0] a, input logic [63:0] b);
    for (int j = 0; j < 4; j++)
      if (a[(3-j)*16 +: 16] != b[(3-j)*16 +: 16]) return j + 2;
    return 5;
  endfunction

  always @(negedge clk) begin
    if (valid_o) begin
      if (!expect_valid) check("spurious_valid_o", {63'd0, valid_o}, 64'd0);
      else begin
        check("mon_result", result_o, exp_res);
        check("mon_cmp", {63'd0, comparison_result_o}, {63'd0, exp_cmp});
      end
    end
  end

  task automatic run_op(input alu_opcode_e op, input logic [63:0] a, input logic [63:0] b,
                        input bit hold, output logic [63:0] got_res, output logic got_cmp);
    int lat;
    int exp_lat;
    logic [63:0] r;
    logic c;
    model(op, a, b, r, c);
    exp_lat = model_latency(a, b);
    @(negedge clk);
    check("ready_o_idle", {63'd0, ready_o}, 64'd1);
    exp_res = r;
    exp_cmp = c;
    expect_valid = 1'b1;
    operator_i = op;
    operand_a_i = a;
    operand_b_i = b;
    valid_i = 1'b1;
    ready_i = !hold;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    operand_a_i = ~a;
    operand_b_i = ~b;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        lat = k;
        break;
      end
    end
    check("latency", 64'(lat), 64'(exp_lat));
    got_res = result_o;
    got_cmp = comparison_result_o;
    if (lat == 0) begin
      expect_valid = 1'b0;
      return;
    end
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("bp_ready_o", {63'd0, ready_o}, 64'd0);
        check("bp_valid_o", {63'd0, valid_o}, 64'd1);
        check("bp_result", result_o, r);
        check("bp_cmp", {63'd0, comparison_result_o}, {63'd0, c});
        if (k == 1) begin
          valid_i = 1'b1;
          operator_i = ALU_LTU;
          operand_a_i = 64'd0;
          operand_b_i = 64'd1;
        end else begin
          valid_i = 1'b0;
        end
      end
      @(negedge clk);
      valid_i = 1'b0;
      ready_i = 1'b1;
    end
    @(posedge clk);
    #1;
    check("valid_o_drop", {63'd0, valid_o}, 64'd0);
    check("ready_o_after_hs", {63'd0, ready_o}, 64'd1);
    expect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic c;
    bit seen;

    repeat (2) @(negedge clk);
    check("rst_ready_o", {63'd0, ready_o}, 64'd0);
    check("rst_valid_o", {63'd0, valid_o}, 64'd0);
    check("rst_result_o", result_o, 64'd0);
    check("rst_cmp_o", {63'd0, comparison_result_o}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready_o", {63'd0, ready_o}, 64'd1);

    run_op(ALU_LTU, 64'h9, 64'hA, 0, r, c);
    check("ltu_9_a_cmp", {63'd0, c}, 64'd1);
    check("ltu_9_a_res", r, 64'd1);
    run_op(ALU_LTU, 64'hA, 64'h9, 0, r, c);
    check("ltu_a_9_cmp", {63'd0, c}, 64'd0);
    run_op(ALU_LTS, 64'h8000_0000_0000_0000, 64'h1, 0, r, c);
    check("lts_neg_cmp", {63'd0, c}, 64'd1);
    run_op(ALU_LTU, 64'h8000_0000_0000_0000, 64'h1, 0, r, c);
    check("ltu_big_cmp", {63'd0, c}, 64'd0);
    run_op(ALU_EQ, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, r, c);
    check("eq_cmp", {63'd0, c}, 64'd1);
    run_op(ALU_NE, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, r, c);
    check("ne_cmp", {63'd0, c}, 64'd0);
    run_op(ALU_GES, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, r, c);
    check("ges_eq_cmp", {63'd0, c}, 64'd1);
    run_op(ALU_GTS, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, r, c);
    check("gts_eq_cmp", {63'd0, c}, 64'd0);
    run_op(ALU_MAX, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, r, c);
    check("max_res", r, 64'h0);
    run_op(ALU_MAXU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, r, c);
    check("maxu_res", r, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(ALU_MINU, 64'h5, 64'h5, 0, r, c);
    check("minu_eq_res", r, 64'h5);
    run_op(ALU_MIN, 64'hFFFF_FFFF_FFFF_FFF0, 64'h7, 0, r, c);
    check("min_neg_res", r, 64'hFFFF_FFFF_FFFF_FFF0);
    run_op(ALU_SLETS, 64'h0000_0001_0000_0000, 64'hFFFF_0000_0000_0000, 0, r, c);
    check("slets_cmp", {63'd0, c}, 64'd0);
    run_op(ALU_GTU, 64'h0000_0000_0000_8001, 64'h0000_0000_0000_8000, 0, r, c);
    check("gtu_low_cmp", {63'd0, c}, 64'd1);
    run_op(ALU_ADD, 64'h77, 64'h77, 0, r, c);
    check("other_op_res", r, 64'h0);
    check("other_op_cmp", {63'd0, c}, 64'd0);

    run_op(ALU_GEU, 64'h0000_0000_1234_0000, 64'h0000_0000_1233_FFFF, 1, r, c);
    check("bp_geu_cmp", {63'd0, c}, 64'd1);

    // Flush during the second scan cycle of an EQ: no result may appear.
    @(negedge clk);
    expect_valid = 1'b0;
    operator_i = ALU_EQ;
    operand_a_i = 64'hDEAD_BEEF_0000_1111;
    operand_b_i = 64'hDEAD_BEEF_0000_1111;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_ready_o", {63'd0, ready_o}, 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("flush_no_valid", {63'd0, valid_o}, 64'd0);
    end

    // Reset while a result is waiting in DONE.
    model(ALU_GEU, 64'h3, 64'h2, r, c);
    @(negedge clk);
    exp_res = r;
    exp_cmp = c;
    expect_valid = 1'b1;
    operator_i = ALU_GEU;
    operand_a_i = 64'h3;
    operand_b_i = 64'h2;
    valid_i = 1'b1;
    ready_i = 1'b0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_done_valid_seen", {63'd0, seen}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_valid = 1'b0;
    check("rst_done_valid_o", {63'd0, valid_o}, 64'd0);
    check("rst_done_result_o", result_o, 64'd0);
    check("rst_done_cmp_o", {63'd0, comparison_result_o}, 64'd0);
    check("rst_done_ready_o", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready_o", {63'd0, ready_o}, 64'd1);

    run_op(ALU_LES, 64'd8, 64'd10, 0, r, c);
    check("les_after_rst_cmp", {63'd0, c}, 64'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_seq_comparator.md
# cv32e40p_seq_comparator

Multi-cycle, parametrised comparison unit for wide operands (64-bit and beyond). It walks operands MSB-first in CHUNK-bit slices and terminates at the first differing slice. It implements the scalar comparison and min/max subset of `alu_opcode_e` from `cv32e40p_pkg`, behind valid/ready handshakes on both sides. It sits beside `cv32e40p_alu` as the wide-datapath comparison engine.

## Interface
- `WIDTH`, 64: operand/result width; must be a multiple of `CHUNK`.
- `CHUNK`, 16: bits examined per scan cycle; NCHUNK = WIDTH/CHUNK, NCHUNK ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `flush_i` in 1: synchronous abort of any in-flight operation.
- `valid_i` in 1: request valid.
- `ready_o` out 1: unit accepts a request (IDLE only).
- `operator_i` in `alu_opcode_e`: operation, sampled on accept.
- `operand_a_i` in WIDTH: operand A, sampled on accept.
- `operand_b_i` in WIDTH: operand B, sampled on accept.
- `valid_o` out 1: result valid.
- `ready_i` in 1: consumer accepts result.
- `result_o` out WIDTH: result word.
- `comparison_result_o` out 1: boolean comparison outcome.

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE → SCAN on `valid_i & ready_o`. A, B and operator are captured, and the chunk index is set to NCHUNK-1.
  - In SCAN, one slice per cycle, starting at the top. SCAN → DONE when the slice differs or the index is 0. Otherwise the index decrements.
  - DONE → IDLE on `ready_i`.
- Signed ops (`ALU_LTS`, `ALU_GES`, `ALU_GTS`, `ALU_LES`, `ALU_SLTS`, `ALU_SLETS`, `ALU_MIN`, `ALU_MAX`): bit WIDTH-1 of both operands is inverted at capture, then everything compares as unsigned.
- Unsigned ops: `ALU_LTU`, `ALU_GEU`, `ALU_GTU`, `ALU_LEU`, `ALU_SLTU`, `ALU_SLETU`, `ALU_MINU`, `ALU_MAXU`. Equality ops: `ALU_EQ`, `ALU_NE`.
- Decision register holds two bits: `lt` and `eq`.
  - At the deciding slice: `lt` = sliceA < sliceB, `eq` = sliceA == sliceB.
  - `eq` is 1 only if every slice matched.
- Comparison outcomes:
  - LT/SLT: `lt`
  - LE/SLET: `lt|eq`
  - GT: `!lt & !eq`
  - GE: `!lt`
  - EQ: `eq`
  - NE: `!eq`
- `result_o` for comparisons is {WIDTH-1 zeros, outcome}.
- MIN/MINU: `result_o` is A if `lt|eq`, else B. MAX/MAXU: `result_o` is A if `!lt`, else B. The original, non-inverted operand is returned in all cases. `comparison_result_o` = `lt` for min/max ops.
- Any other opcode goes through the full SCAN path. Its result is `result_o` = 0 and `comparison_result_o` = 0.
- `flush_i`: the next state is IDLE from any state, and the pending result is discarded. `flush_i` wins over `valid_i` in the same cycle.
- While `rst` is high: state IDLE, `valid_o` = 0, `result_o` = 0, `comparison_result_o` = 0, `ready_o` = 0. After `rst` deasserts, `ready_o` = 1.

## Timing
- Accept at edge 0. SCAN slice j (j = 1..NCHUNK) is evaluated in cycle j.
- `valid_o` rises at edge d+1, where d is the index of the deciding slice.
  - Minimum latency: 2 cycles (top slice differs).
  - Maximum latency: NCHUNK+1 cycles (operands equal, or only the low slice differs).
- `valid_o`, `result_o` and `comparison_result_o` are registered. They are stable throughout DONE and do not change while `ready_i` = 0.
- `ready_o` = 1 only in IDLE. Back-to-back throughput: one operation per (latency+1) cycles. `valid_i` in non-IDLE states is ignored, not queued.
- `valid_o` falls on the edge after `valid_o & ready_i`. `ready_o` is 1 in that same following cycle.
- Reset mid-SCAN or mid-DONE: outputs clear immediately (asynchronously), and the result is never presented.
- NCHUNK = 1 is a degenerate case: every operation takes 2 cycles.

## Test plan
Scenarios below use WIDTH = 64 and CHUNK = 16.
- LTU, A = 0x9, B = 0xA: 4 SCAN cycles; `valid_o` at edge 5; cmp = 1, result = 0x1. Repeat with A = 0xA, B = 0x9: cmp = 0.
- LTS, A = 0x8000_0000_0000_0000, B = 0x1: decided in the top slice; `valid_o` at edge 2; cmp = 1. Same operands with LTU: cmp = 0.
- EQ, A = B = 0x1234_5678_9ABC_DEF0: `valid_o` at edge 5, cmp = 1. Same operands with NE: cmp = 0. Same operands with GES: cmp = 1, and with GTS: cmp = 0.
- MAX, A = 0xFFFF_FFFF_FFFF_FFFF, B = 0: result = 0. MAXU: result = 0xFFFF_FFFF_FFFF_FFFF. MINU with A = B = 5: result = 5.
- Backpressure: hold `ready_i` = 0 for 3 cycles in DONE, then raise it.
  - During the hold, `valid_o`, `result_o` and cmp stay stable, `ready_o` = 0, and a `valid_i` pulse is ignored.
  - `ready_o` = 1 on the edge after the handshake.
- Abort:
  - `flush_i` in SCAN cycle 2 of an EQ op: the unit is in IDLE next cycle, with no `valid_o` pulse.
  - `rst` pulse in DONE: `valid_o` drops immediately. A subsequent LES with A = 8, B = 10 completes with cmp = 1.
